// File: rtl/gb_timer_responder_if.sv
// Bus bundle between the CPU (MAR/MDR side) and the GameBoy timer responder.
//   addr   : CPU bus address (MAR)
//   rd/wr  : single-cycle read / write strobes
//   wdata  : write data (MDR out)
//   rdata  : registered read data
//   rvalid : rdata valid for one cycle
//   hit    : combinational address-window decode, ORed into the fabric decode
interface gb_timer_responder_if;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        hit;

    modport master (
        output addr, rd, wr, wdata,
        input  rdata, rvalid, hit
    );

    modport slave (
        input  addr, rd, wr, wdata,
        output rdata, rvalid, hit
    );
endinterface

// File: rtl/gb_timer_responder.sv
// GameBoy timer peripheral (DIV/TIMA/TMA/TAC) as a responder on the CPU bus.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   tick_en   : T-cycle enable for the divider and reload step
//   bus       : slave side of gb_timer_responder_if (addr/rd/wr/wdata/rdata/rvalid/hit)
//   irq_timer : one-cycle timer interrupt request on TIMA reload
module gb_timer_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          DIV_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_en,
    gb_timer_responder_if.slave    bus,
    output logic                   irq_timer
);

    logic [DIV_W-1:0] counter;
    logic [7:0]       tima;
    logic [7:0]       tma;
    logic [2:0]       tac;
    logic             reload_pend;
    logic             prev_bit;

    logic [15:0]      offset;
    logic [1:0]       reg_sel;
    logic             wr_div;
    logic             wr_tima;
    logic             wr_tma;
    logic             wr_tac;
    logic             rd_ok;
    logic [7:0]       rd_mux;
    logic             sel_bit;
    logic             timer_in;
    logic             tima_inc;

    // Unsigned subtraction makes the window check independent of BASE_ADDR alignment.
    assign offset  = bus.addr - BASE_ADDR;
    assign bus.hit = (offset[15:2] == 14'd0);
    assign reg_sel = offset[1:0];

    assign wr_div  = bus.wr && bus.hit && (reg_sel == 2'd0);
    assign wr_tima = bus.wr && bus.hit && (reg_sel == 2'd1);
    assign wr_tma  = bus.wr && bus.hit && (reg_sel == 2'd2);
    assign wr_tac  = bus.wr && bus.hit && (reg_sel == 2'd3);
    // A simultaneous write suppresses the read.
    assign rd_ok   = bus.rd && !bus.wr && bus.hit;

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            2'd0:    rd_mux = counter[15:8];
            2'd1:    rd_mux = tima;
            2'd2:    rd_mux = tma;
            default: rd_mux = {5'b11111, tac};
        endcase
    end

    always_comb begin
        sel_bit = 1'b0;
        case (tac[1:0])
            2'b00:   sel_bit = counter[9];
            2'b01:   sel_bit = counter[3];
            2'b10:   sel_bit = counter[5];
            default: sel_bit = counter[7];
        endcase
    end

    // The enable is ANDed in before edge detection, so disabling the timer or
    // clearing the divider while the selected bit is high produces a falling edge.
    assign timer_in = sel_bit & tac[2];
    assign tima_inc = prev_bit & ~timer_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter     <= '0;
            tima        <= 8'h00;
            tma         <= 8'h00;
            tac         <= 3'b000;
            reload_pend <= 1'b0;
            prev_bit    <= 1'b0;
            irq_timer   <= 1'b0;
            bus.rdata   <= 8'h00;
            bus.rvalid  <= 1'b0;
        end else begin
            // prev_bit tracks timer_in every clock, not only on ticks.
            prev_bit  <= timer_in;
            irq_timer <= 1'b0;

            if (wr_div) begin
                counter <= '0;
            end else if (tick_en) begin
                counter <= counter + DIV_W'(1);
            end

            if (wr_tac) begin
                tac <= bus.wdata[2:0];
            end
            if (wr_tma) begin
                tma <= bus.wdata;
            end

            // TIMA priority: CPU write (also cancels a pending reload), then the
            // delayed reload, then the normal increment.
            if (wr_tima) begin
                tima        <= bus.wdata;
                reload_pend <= 1'b0;
            end else if (reload_pend && tick_en) begin
                tima        <= wr_tma ? bus.wdata : tma;
                irq_timer   <= 1'b1;
                reload_pend <= 1'b0;
            end else if (tima_inc) begin
                if (tima == 8'hFF) begin
                    tima        <= 8'h00;
                    reload_pend <= 1'b1;
                end else begin
                    tima <= tima + 8'd1;
                end
            end

            bus.rvalid <= rd_ok;
            if (rd_ok) begin
                bus.rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_gb_timer_responder.sv
module tb_gb_timer_responder;

    logic clk = 1'b0;
    logic rst;
    logic tick_en;
    logic irq_timer;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gb_timer_responder_if bus ();

    gb_timer_responder #(
        .BASE_ADDR(16'hFF04),
        .DIV_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_en  (tick_en),
        .bus      (bus),
        .irq_timer(irq_timer)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        step(1);
        bus.wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic v);
        bus.addr = a;
        bus.rd   = 1'b1;
        step(1);
        bus.rd   = 1'b0;
        d = bus.rdata;
        v = bus.rvalid;
    endtask

    task automatic ticks(input int n);
        tick_en = 1'b1;
        step(n);
        tick_en = 1'b0;
    endtask

    // DIV cleared first so later register writes see counter == 0; TIMA last
    // so it overrides anything the DIV clear might have caused.
    task automatic setup(input logic [7:0] tac_v, input logic [7:0] tma_v, input logic [7:0] tima_v);
        bus_write(16'hFF04, 8'h00);
        bus_write(16'hFF07, tac_v);
        bus_write(16'hFF06, tma_v);
        bus_write(16'hFF05, tima_v);
        step(2);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       v;
        logic [7:0] exp_r [4];
        exp_r[0] = 8'h00; exp_r[1] = 8'h00; exp_r[2] = 8'h00; exp_r[3] = 8'hF8;
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        checks++;
        if (irq_timer !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs irq=%b rvalid=%b rdata=%h want 0/0/00", irq_timer, bus.rvalid, bus.rdata);
        end
        bus.addr = 16'hFF07;
        #1;
        checks++;
        if (bus.hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_ff07 got %b want 1", bus.hit);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(16'hFF04 + 16'(i), d, v);
            checks++;
            if (v !== 1'b1 || d !== exp_r[i]) begin
                errors++;
                $display("FAIL reset_read_%0d rvalid=%b rdata=%h want 1/%h", i, v, d, exp_r[i]);
            end
        end
        step(1);
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_one_cycle got %b want 0", bus.rvalid);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        logic       v;
        setup(8'h05, 8'hF0, 8'hFE);
        ticks(16);
        step(2);
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL tima_16_ticks got %h want ff", d);
        end
        ticks(16);
        step(2);
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h00 || irq_timer !== 1'b0) begin
            errors++;
            $display("FAIL tima_32_ticks got %h irq=%b want 00 irq=0", d, irq_timer);
        end
        tick_en = 1'b1;
        step(1);
        tick_en = 1'b0;
        checks++;
        if (irq_timer !== 1'b1) begin
            errors++;
            $display("FAIL irq_on_reload got %b want 1", irq_timer);
        end
        step(1);
        checks++;
        if (irq_timer !== 1'b0) begin
            errors++;
            $display("FAIL irq_single_cycle got %b want 0", irq_timer);
        end
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'hF0) begin
            errors++;
            $display("FAIL tima_reloaded got %h want f0", d);
        end
    endtask

    task automatic test_tima_write_cancel;
        logic [7:0] d;
        logic       v;
        setup(8'h05, 8'hF0, 8'hFE);
        ticks(32);
        step(2);
        tick_en = 1'b1;
        bus_write(16'hFF05, 8'h42);
        tick_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (irq_timer !== 1'b0) begin
                errors++;
                $display("FAIL cancel_no_irq_%0d got %b want 0", i, irq_timer);
            end
            step(1);
        end
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h42) begin
            errors++;
            $display("FAIL cancel_tima got %h want 42", d);
        end
    endtask

    task automatic test_tma_write_reload;
        logic [7:0] d;
        logic       v;
        setup(8'h05, 8'hF0, 8'hFE);
        ticks(32);
        step(2);
        tick_en = 1'b1;
        bus_write(16'hFF06, 8'h5A);
        tick_en = 1'b0;
        checks++;
        if (irq_timer !== 1'b1) begin
            errors++;
            $display("FAIL tma_collide_irq got %b want 1", irq_timer);
        end
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL tma_collide_tima got %h want 5a", d);
        end
    endtask

    task automatic test_falling_edge_quirks;
        logic [7:0] d;
        logic       v;
        setup(8'h05, 8'h00, 8'h10);
        ticks(8);
        step(2);
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h10) begin
            errors++;
            $display("FAIL pre_div_clear_tima got %h want 10", d);
        end
        bus_write(16'hFF04, 8'hAB);
        step(2);
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("FAIL div_clear_inc got %h want 11", d);
        end
        ticks(8);
        step(2);
        bus_write(16'hFF07, 8'h01);
        step(2);
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h12) begin
            errors++;
            $display("FAIL tac_disable_inc got %h want 12", d);
        end
        bus_read(16'hFF07, d, v);
        checks++;
        if (d !== 8'hF9) begin
            errors++;
            $display("FAIL tac_read got %h want f9", d);
        end
    endtask

    task automatic test_rd_wr_same;
        logic [7:0] d;
        logic       v;
        bus.addr  = 16'hFF06;
        bus.wdata = 8'h77;
        bus.rd    = 1'b1;
        bus.wr    = 1'b1;
        step(1);
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rdwr_rvalid got %b want 0", bus.rvalid);
        end
        bus_read(16'hFF06, d, v);
        checks++;
        if (d !== 8'h77) begin
            errors++;
            $display("FAIL rdwr_tma got %h want 77", d);
        end
    endtask

    task automatic test_tick_gate;
        logic [7:0] d;
        logic       v;
        setup(8'h05, 8'h00, 8'h00);
        ticks(768);
        step(2);
        bus_read(16'hFF04, d, v);
        checks++;
        if (d !== 8'h03) begin
            errors++;
            $display("FAIL div_768 got %h want 03", d);
        end
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h30) begin
            errors++;
            $display("FAIL tima_768 got %h want 30", d);
        end
        step(100);
        bus_read(16'hFF04, d, v);
        checks++;
        if (d !== 8'h03) begin
            errors++;
            $display("FAIL div_gated got %h want 03", d);
        end
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h30) begin
            errors++;
            $display("FAIL tima_gated got %h want 30", d);
        end
        ticks(16);
        step(2);
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h31) begin
            errors++;
            $display("FAIL counter_resume got %h want 31", d);
        end
        bus.addr = 16'hFF03;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_ff03 got %b want 0", bus.hit);
        end
        bus.addr = 16'hFF08;
        bus.rd   = 1'b1;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_ff08 got %b want 0", bus.hit);
        end
        step(1);
        bus.rd = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h31) begin
            errors++;
            $display("FAIL miss_read rvalid=%b rdata=%h want 0/31", bus.rvalid, bus.rdata);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       v;
        setup(8'h05, 8'hF0, 8'hFE);
        ticks(32);
        step(2);
        bus_read(16'hFF07, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'hFD) begin
            errors++;
            $display("FAIL pre_reset_read rvalid=%b rdata=%h want 1/fd", v, d);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 8'h00 || irq_timer !== 1'b0) begin
            errors++;
            $display("FAIL async_reset rvalid=%b rdata=%h irq=%b want 0/00/0", bus.rvalid, bus.rdata, irq_timer);
        end
        tick_en = 1'b1;
        step(2);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (irq_timer !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_irq_%0d got %b want 0", i, irq_timer);
            end
        end
        tick_en = 1'b0;
        bus_read(16'hFF05, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_tima got %h want 00", d);
        end
        bus_read(16'hFF06, d, v);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_tma got %h want 00", d);
        end
        bus_read(16'hFF07, d, v);
        checks++;
        if (d !== 8'hF8) begin
            errors++;
            $display("FAIL post_reset_tac got %h want f8", d);
        end
    endtask

    initial begin
        rst       = 1'b0;
        tick_en   = 1'b0;
        bus.addr  = 16'h0000;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.wdata = 8'h00;
        test_reset();
        test_overflow();
        test_tima_write_cancel();
        test_tma_write_reload();
        test_falling_edge_quirks();
        test_rd_wr_same();
        test_tick_gate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
